// File: rtl/game_pkg.sv
// Shared definitions for the naval battle game-flow controller.
// Holds the 2-bit state encodings used on game_state_code, the FSM state type,
// and the player-index wrap helper used for turn order and target selection.
package game_pkg;

  localparam logic [1:0] ST_OFF    = 2'b00;
  localparam logic [1:0] ST_PREP   = 2'b01;
  localparam logic [1:0] ST_ATTACK = 2'b10;
  localparam logic [1:0] ST_OVER   = 2'b11;

  typedef enum logic [1:0] {
    S_OFF    = ST_OFF,
    S_PREP   = ST_PREP,
    S_ATTACK = ST_ATTACK,
    S_OVER   = ST_OVER
  } state_t;

  // Next player in round-robin order; n-1 wraps back to 0.
  function automatic int unsigned next_player(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/game_state_controller_hit_counter.sv
// Saturating hits-received counter for one player.
// Ports: clk, rst_n, clear (sync clear), inc (count one hit); count, reached (count==HIT_TARGET).
// Latency: count updates 1 cycle after inc; no backpressure, inc is ignored once saturated.
module player_hit_counter #(
  parameter int HIT_TARGET = 10,
  parameter int HIT_W      = $clog2(HIT_TARGET + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [HIT_W-1:0] count,
  output logic             reached
);

  assign reached = (count == HIT_W'(HIT_TARGET));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !reached) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/game_state_controller.sv
// Game-flow controller: OFF -> PREP (placement per player) -> ATTACK (turns) -> OVER.
// Ports: start/abort/place_ok/shot/hit pulses in; state code, phase enables, turn, winner out.
// Latency: every input pulse shows on the outputs 1 cycle later; pulses not used in a state are dropped.
module game_state_controller
  import game_pkg::*;
#(
  parameter int N_PLAYERS        = 2,
  parameter int SHIPS_PER_PLAYER = 4,
  parameter int HIT_TARGET       = 10,
  parameter int PLAYER_W         = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
  parameter int SHIP_W           = $clog2(SHIPS_PER_PLAYER + 1),
  parameter int HIT_W            = $clog2(HIT_TARGET + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                place_ok,
  input  logic                shot,
  input  logic                hit,
  output logic [1:0]          game_state_code,
  output logic                enablePreparation,
  output logic                enableAttack,
  output logic                enable,
  output logic [PLAYER_W-1:0] current_player,
  output logic [PLAYER_W-1:0] target_player,
  output logic [SHIP_W-1:0]   ships_placed,
  output logic [PLAYER_W-1:0] winner,
  output logic                winner_valid
);

  localparam logic [SHIP_W-1:0]   LAST_SHIP   = SHIP_W'(SHIPS_PER_PLAYER - 1);
  localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(N_PLAYERS - 1);
  localparam logic [HIT_W-1:0]    FINAL_HIT   = HIT_W'(HIT_TARGET - 1);

  state_t              state, state_nxt;
  logic [PLAYER_W-1:0] player_nxt;
  logic [SHIP_W-1:0]   ships_nxt;
  logic [PLAYER_W-1:0] winner_nxt;
  logic                clear_hits;
  logic                hit_evt;
  logic [N_PLAYERS-1:0] hit_inc;
  logic [N_PLAYERS-1:0] hit_reached;
  logic [HIT_W-1:0]    hit_cnt [N_PLAYERS];
  logic [HIT_W-1:0]    tgt_cnt;

  assign target_player = PLAYER_W'(next_player(32'(current_player), N_PLAYERS));

  // Hit count of the player currently being shot at.
  always_comb begin
    tgt_cnt = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (target_player == PLAYER_W'(i)) tgt_cnt = hit_cnt[i];
    end
  end

  always_comb begin
    hit_inc = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      hit_inc[i] = hit_evt && (target_player == PLAYER_W'(i)) && !hit_reached[i];
    end
  end

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_hits
    player_hit_counter #(
      .HIT_TARGET(HIT_TARGET),
      .HIT_W     (HIT_W)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear_hits),
      .inc    (hit_inc[g]),
      .count  (hit_cnt[g]),
      .reached(hit_reached[g])
    );
  end

  // Next-state logic; priority abort > start > place_ok > shot.
  always_comb begin
    state_nxt  = state;
    player_nxt = current_player;
    ships_nxt  = ships_placed;
    winner_nxt = winner;
    clear_hits = 1'b0;
    hit_evt    = 1'b0;
    if (abort) begin
      state_nxt  = S_OFF;
      player_nxt = '0;
      ships_nxt  = '0;
      winner_nxt = '0;
      clear_hits = 1'b1;
    end else begin
      case (state)
        S_OFF, S_OVER: begin
          if (start) begin
            state_nxt  = S_PREP;
            player_nxt = '0;
            ships_nxt  = '0;
            winner_nxt = '0;
            clear_hits = 1'b1;
          end
        end
        S_PREP: begin
          if (place_ok) begin
            if (ships_placed == LAST_SHIP) begin
              ships_nxt = '0;
              if (current_player == LAST_PLAYER) begin
                state_nxt  = S_ATTACK;
                player_nxt = '0;
              end else begin
                player_nxt = current_player + 1'b1;
              end
            end else begin
              ships_nxt = ships_placed + 1'b1;
            end
          end
        end
        S_ATTACK: begin
          if (shot) begin
            if (hit) begin
              // Shooter keeps the turn; the final hit freezes it as the winner.
              hit_evt = 1'b1;
              if (tgt_cnt == FINAL_HIT) begin
                state_nxt  = S_OVER;
                winner_nxt = current_player;
              end
            end else begin
              player_nxt = target_player;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_OFF;
      current_player <= '0;
      ships_placed   <= '0;
      winner         <= '0;
    end else begin
      state          <= state_nxt;
      current_player <= player_nxt;
      ships_placed   <= ships_nxt;
      winner         <= winner_nxt;
    end
  end

  assign game_state_code   = state;
  assign enablePreparation = (state == S_PREP);
  assign enableAttack      = (state == S_ATTACK);
  assign enable            = enablePreparation | enableAttack;
  assign winner_valid      = (state == S_OVER);

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller (2 players, 4 ships, 3 hits to win).
// Expected output snapshots are queued as each step is driven and compared after the edge.
module tb_game_state_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, place_ok = 1'b0, shot = 1'b0, hit = 1'b0;
  logic [1:0] game_state_code;
  logic       enablePreparation, enableAttack, enable, winner_valid;
  logic [0:0] current_player, target_player, winner;
  logic [2:0] ships_placed;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int code;
    int cur;
    int ships;
    int wv;
    int win;
  } exp_t;

  exp_t exp_q[$];

  game_state_controller #(
    .N_PLAYERS       (2),
    .SHIPS_PER_PLAYER(4),
    .HIT_TARGET      (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .place_ok         (place_ok),
    .shot             (shot),
    .hit              (hit),
    .game_state_code  (game_state_code),
    .enablePreparation(enablePreparation),
    .enableAttack     (enableAttack),
    .enable           (enable),
    .current_player   (current_player),
    .target_player    (target_player),
    .ships_placed     (ships_placed),
    .winner           (winner),
    .winner_valid     (winner_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_code"},   int'(game_state_code),   e.code);
    chk({tag, "_prep"},   int'(enablePreparation), int'(e.code == 1));
    chk({tag, "_atk"},    int'(enableAttack),      int'(e.code == 2));
    chk({tag, "_en"},     int'(enable),            int'(e.code == 1 || e.code == 2));
    chk({tag, "_cur"},    int'(current_player),    e.cur);
    chk({tag, "_tgt"},    int'(target_player),     (e.cur + 1) % 2);
    chk({tag, "_ships"},  int'(ships_placed),      e.ships);
    chk({tag, "_wv"},     int'(winner_valid),      e.wv);
    chk({tag, "_win"},    int'(winner),            e.win);
  endtask

  // Drive one cycle of pulses from a negedge, compare at the following negedge.
  task automatic step(input string tag, input logic s, a, p, sh, h,
                      input int ecode, ecur, eships, ewv, ewin);
    exp_q.push_back('{ecode, ecur, eships, ewv, ewin});
    start = s; abort = a; place_ok = p; shot = sh; hit = h;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; place_ok = 1'b0; shot = 1'b0; hit = 1'b0;
    @(negedge clk);
    check_out(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle", 0,0,0,0,0, 0,0,0,0,0);

    // Placement: 4 ships for player 0, then 4 for player 1.
    step("start", 1,0,0,0,0, 1,0,0,0,0);
    step("p0_1", 0,0,1,0,0, 1,0,1,0,0);
    step("p0_2", 0,0,1,0,0, 1,0,2,0,0);
    step("p0_3", 0,0,1,0,0, 1,0,3,0,0);
    step("p0_4", 0,0,1,0,0, 1,1,0,0,0);
    step("p1_1", 0,0,1,0,0, 1,1,1,0,0);
    step("p1_2", 0,0,1,0,0, 1,1,2,0,0);
    step("p1_3", 0,0,1,0,0, 1,1,3,0,0);
    step("p1_4", 0,0,1,0,0, 2,0,0,0,0);

    // Attack phase.
    step("place_in_atk", 0,0,1,0,0, 2,0,0,0,0);
    step("start_in_atk", 1,0,0,0,0, 2,0,0,0,0);
    step("miss", 0,0,0,1,0, 2,1,0,0,0);
    step("hit1", 0,0,0,1,1, 2,1,0,0,0);
    chk("hits0_a", int'(dut.hit_cnt[0]), 1);
    step("hit_no_shot", 0,0,0,0,1, 2,1,0,0,0);
    chk("hits0_b", int'(dut.hit_cnt[0]), 1);
    step("hit2", 0,0,0,1,1, 2,1,0,0,0);
    step("hit3", 0,0,0,1,1, 3,1,0,1,1);
    chk("hits0_c", int'(dut.hit_cnt[0]), 3);
    step("over_shot", 0,0,0,1,1, 3,1,0,1,1);
    step("over_place", 0,0,1,0,0, 3,1,0,1,1);
    chk("hits0_sat", int'(dut.hit_cnt[0]), 3);

    // Restart from OVER clears everything.
    step("restart", 1,0,0,0,0, 1,0,0,0,0);
    chk("hits0_clr", int'(dut.hit_cnt[0]), 0);
    step("g2_p1", 0,0,1,0,0, 1,0,1,0,0);
    step("g2_p2", 0,0,1,0,0, 1,0,2,0,0);
    step("shot_in_prep", 0,0,0,1,1, 1,0,2,0,0);
    step("abort_start", 1,1,0,0,0, 0,0,0,0,0);

    // Third game: simultaneous shot/place in PREP, turn wrap in ATTACK.
    step("g3_start", 1,0,0,0,0, 1,0,0,0,0);
    step("place_and_shot", 0,0,1,1,1, 1,0,1,0,0);
    step("g3_p0_2", 0,0,1,0,0, 1,0,2,0,0);
    step("g3_p0_3", 0,0,1,0,0, 1,0,3,0,0);
    step("g3_p0_4", 0,0,1,0,0, 1,1,0,0,0);
    for (int i = 1; i <= 3; i++) step("g3_p1", 0,0,1,0,0, 1,1,i,0,0);
    step("g3_p1_4", 0,0,1,0,0, 2,0,0,0,0);
    step("g3_miss_a", 0,0,0,1,0, 2,1,0,0,0);
    step("g3_miss_wrap", 0,0,0,1,0, 2,0,0,0,0);
    step("g3_hit", 0,0,0,1,1, 2,0,0,0,0);
    chk("hits1_a", int'(dut.hit_cnt[1]), 1);

    // Asynchronous reset mid-ATTACK takes effect without a clock edge.
    exp_q.push_back('{0, 0, 0, 0, 0});
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst");
    chk("hits1_rst", int'(dut.hit_cnt[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 0,0,0,0,0, 0,0,0,0,0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
